// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - parametrised two-read/two-write register file with busy scoreboard
// Port 1 overrides port 0 on a shared destination; issue wins over writeback on busy bits.
module reg_file_sb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int R0_ZERO = 1,
  parameter int BYPASS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     rd_sel_a,
  output logic [DATA_W-1:0]     rd_data_a,
  output logic                  rd_busy_a,
  input  logic [ADDR_W-1:0]     rd_sel_b,
  output logic [DATA_W-1:0]     rd_data_b,
  output logic                  rd_busy_b,
  input  logic                  wr0_en,
  input  logic [ADDR_W-1:0]     wr0_sel,
  input  logic [DATA_W-1:0]     wr0_data,
  input  logic [DATA_W/8-1:0]   wr0_be,
  input  logic                  wr1_en,
  input  logic [ADDR_W-1:0]     wr1_sel,
  input  logic [DATA_W-1:0]     wr1_data,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_sel,
  output logic [2**ADDR_W-1:0]  busy_vec
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] regs     [DEPTH];
  logic [DATA_W-1:0] regs_nxt [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_nxt;

  // Post-write view of every register; doubles as the bypass source.
  always_comb begin
    for (int n = 0; n < DEPTH; n++) begin
      regs_nxt[n] = regs[n];
      busy_nxt[n] = busy_q[n];
      if (wr0_en && wr0_sel == ADDR_W'(n)) begin
        for (int i = 0; i < NB; i++) begin
          if (wr0_be[i]) regs_nxt[n][8*i +: 8] = wr0_data[8*i +: 8];
        end
        busy_nxt[n] = 1'b0;
      end
      if (wr1_en && wr1_sel == ADDR_W'(n)) begin
        regs_nxt[n] = wr1_data;
        busy_nxt[n] = 1'b0;
      end
      if (iss_en && iss_sel == ADDR_W'(n)) busy_nxt[n] = 1'b1;
      if (R0_ZERO != 0 && n == 0) begin
        regs_nxt[n] = '0;
        busy_nxt[n] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < DEPTH; n++) regs[n] <= '0;
      busy_q <= '0;
    end else begin
      for (int n = 0; n < DEPTH; n++) regs[n] <= regs_nxt[n];
      busy_q <= busy_nxt;
    end
  end

  // Reset gates the bypass path so reads are zero while reset is held.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (!reset) begin
      rd_data_a = (BYPASS != 0) ? regs_nxt[rd_sel_a] : regs[rd_sel_a];
      rd_data_b = (BYPASS != 0) ? regs_nxt[rd_sel_b] : regs[rd_sel_b];
    end
  end

  assign rd_busy_a = busy_q[rd_sel_a];
  assign rd_busy_b = busy_q[rd_sel_b];
  assign busy_vec  = busy_q;

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the 16x32 single-write register file.
- Configurable width and depth; two combinational read ports; two write ports with byte enables on port 0.
- Optional hardwired-zero register 0 and optional write-to-read bypass.
- Per-register busy scoreboard: the issue stage marks a destination busy, and writeback clears it. This lets the control unit stall on read-after-write hazards.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 4, select width; depth = 2**ADDR_W.
- R0_ZERO, 1, if 1: register 0 always reads 0, ignores writes, and is never busy.
- BYPASS, 1, if 1: a same-cycle write to the selected register is forwarded to read data.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all registers and busy bits
- rd_sel_a  in  ADDR_W  read port A select
- rd_data_a  out  DATA_W  read port A data
- rd_busy_a  out  1  busy bit of rd_sel_a
- rd_sel_b  in  ADDR_W  read port B select
- rd_data_b  out  DATA_W  read port B data
- rd_busy_b  out  1  busy bit of rd_sel_b
- wr0_en  in  1  write port 0 enable
- wr0_sel  in  ADDR_W  write port 0 destination
- wr0_data  in  DATA_W  write port 0 data
- wr0_be  in  DATA_W/8  write port 0 byte enables; bit i covers byte i
- wr1_en  in  1  write port 1 enable; always full-word; higher priority
- wr1_sel  in  ADDR_W  write port 1 destination
- wr1_data  in  DATA_W  write port 1 data
- iss_en  in  1  mark destination busy
- iss_sel  in  ADDR_W  destination to mark busy
- busy_vec  out  2**ADDR_W  all busy bits, bit n = register n

Behaviour:
- Reset (async, active-high): every register = 0 and busy_vec = 0 immediately. Read outputs therefore show 0 and rd_busy_* = 0 while reset is high.
- Reset mid-operation discards pending writes and issues on that edge.
- Storage updates on the rising clk edge when reset is low.
- Write port 0: only bytes with wr0_be[i]=1 are updated. wr0_en=1 with wr0_be=0 writes nothing but still clears busy.
- Write port 1: full-word write.
- Both ports to the same register in one cycle: port 1 data wins in every byte, regardless of wr0_be.
- Busy bit n, next-state priority (highest first):
  - iss_en && iss_sel==n -> set.
  - Else any enabled write to n -> clear.
  - Else hold.
- Issue and writeback to the same register in one cycle leave it busy: the new producer is pending.
- Issue to a register that is already busy keeps it set.
- R0_ZERO=1:
  - Writes to register 0 are ignored; storage stays 0.
  - Issue to register 0 is ignored.
  - rd_data = 0 and rd_busy = 0 for select 0.
  - busy_vec[0] is always 0.
- Reads are combinational, zero latency.
- BYPASS=0: rd_data shows the stored value; the write is visible the cycle after the edge.
- BYPASS=1: if an enabled write in the current cycle targets rd_sel, rd_data shows the post-write value. This means merged bytes for port 0, port 1 winning over port 0, and R0_ZERO still applying.
- rd_busy is always the registered busy bit, never bypassed.
- Out-of-range values cannot occur; depth is exactly 2**ADDR_W.
- No X on any output after reset; synthesizable, no latches.

Test Plan (DATA_W=32, ADDR_W=4, R0_ZERO=1, BYPASS=1 unless stated):
- Reset while registers hold data:
  - Stimulus: write 0xDEADBEEF to r5 and issue r7, then assert reset between clock edges.
  - Required response: rd_data_a(sel=5) = 0 and busy_vec = 0 immediately, without waiting for a clock edge.
- Byte-enable merge:
  - Stimulus: r3 = 0x11223344; then wr0 sel=3, data=0xAABBCCDD, be=4'b0101.
  - Required response: the same cycle reads 0x11BB33DD via bypass; the next cycle reads the same value from storage.
- Dual-write collision:
  - Stimulus: wr0 (sel=9, data=0x1, be=4'hF) and wr1 (sel=9, data=0x2) in the same cycle.
  - Required response: r9 = 0x2. With BYPASS=0, rd_data_b(sel=9) shows the old value that cycle and 0x2 the next.
- Scoreboard:
  - Stimulus: issue r4, then wait 3 cycles.
  - Required response: rd_busy_a = 1 and busy_vec = 0x0010.
  - Stimulus: wr1 to r4 together with iss_sel=4.
  - Required response: r4 stays busy.
  - Stimulus: wr0 to r4 alone with be=0.
  - Required response: busy clears and the data is unchanged.
- Register zero:
  - Stimulus: wr1 sel=0, data=0xFFFFFFFF plus iss_sel=0.
  - Required response: rd_data_a(sel=0) = 0 and rd_busy_a = 0.
  - Stimulus: repeat with R0_ZERO=0.
  - Required response: reads 0xFFFFFFFF and busy_vec[0] = 1.
- Two-port independence:
  - Stimulus: r1 = 0xA5A5A5A5 and r2 = 0x5A5A5A5A, read simultaneously on A and B while wr1 writes r2 = 0x0.
  - Required response: A = 0xA5A5A5A5 and B = 0x0 (bypassed).
